morse_keyer_ctrl: RTL and testbench
===================================

// Module: morse_keyer_ctrl
// PURPOSE
//  Sequencer for the morse symbol buffer. Times debounced key presses and gaps,
//  classifies presses as dot/dash and pulses new_dot/new_dash into the buffer.
//  On an inter-letter gap it offers the buffered letter downstream (valid/ready),
//  then pulses clear. Optionally flags inter-word gaps.
// PARAMETERS
//  UNIT_CYCLES      1_000_000  clk cycles per morse time unit (one dot)
//  DEBOUNCE_CYCLES  50_000     key level must be stable this long to be accepted
//  MAX_SYMBOLS      6          buffer capacity; must match the buffer's limit
//  CNT_W            24         timer width; must hold 10*UNIT_CYCLES
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous reset, active-high
//  key_in        in   1  raw key, 1 = pressed, asynchronous to clk
//  symbol_count  in   3  current symbol count from the buffer
//  new_dot       out  1  one-cycle pulse: append dot
//  new_dash      out  1  one-cycle pulse: append dash
//  clear         out  1  one-cycle pulse: empty the buffer
//  letter_valid  out  1  buffered letter is complete; held until letter_ready
//  letter_ready  in   1  downstream decoder accepts the letter
//  word_gap      out  1  one-cycle pulse: inter-word gap detected
//  overflow      out  1  sticky: symbol dropped because buffer was full
//  busy          out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timer 0, sync/debounce regs 0.
//  - key_in goes through a 2-FF synchroniser, then the debouncer. All timing
//    below uses the debounced level.
//  - States: IDLE -> PRESS on rising edge; PRESS -> GAP on falling edge;
//    GAP -> PRESS on rising edge; GAP -> COMMIT when gap timer = 3*UNIT and
//    symbol_count > 0; COMMIT -> CLEAR when letter_valid && letter_ready;
//    CLEAR -> GAP after 1 cycle. GAP -> IDLE when the gap timer saturates.
//  - Timer resets to 0 on every debounced edge. It saturates at 10*UNIT_CYCLES.
//  - Press classification happens on the falling edge. The pulse is driven the
//    cycle after the debounced fall.
//    len < 2*UNIT -> new_dot. 2*UNIT <= len < 10*UNIT -> new_dash.
//    len >= 10*UNIT -> discarded, no pulse.
//  - If symbol_count >= MAX_SYMBOLS at classification, no pulse is driven and
//    overflow is set. overflow is cleared only by clear or rst.
//  - new_dot and new_dash are never high in the same cycle.
//  - letter_valid rises on entry to COMMIT and is held until the handshake.
//    letter_ready while valid is low is ignored.
//  - clear is high for exactly the one CLEAR cycle.
//  - A rising edge while in COMMIT or CLEAR is not timed. The press is dropped
//    and overflow is set. The FSM re-enters GAP and waits for the next edge.
//  - Reset mid-press: no pulse is emitted and the FSM returns to IDLE.
// CONFIGURATION
//  MORSE_CTRL_WORD_GAP_EN defined:
//    - In GAP, after a CLEAR and with no press since, word_gap pulses once when
//      the gap timer = 7*UNIT.
//    - It is re-armed by the next press.
//  MORSE_CTRL_WORD_GAP_EN undefined: word_gap tied 0; no word-gap logic.
// STRUCTURE
//  morse_pkg: state enum (IDLE, PRESS, GAP, COMMIT, CLEAR); symbol codes
//    SYM_DOT=2'b01, SYM_DASH=2'b10; thresholds DASH_UNITS=2, LETTER_UNITS=3,
//    WORD_UNITS=7, MAX_UNITS=10.
//  Sub-module morse_key_debounce: synchroniser + stable-count debouncer,
//    outputs the debounced level plus rise/fall pulses.
// TESTING  (UNIT_CYCLES=10, DEBOUNCE_CYCLES=2)
//  1. Debounced press of 10 cycles, then release -> one new_dot pulse; no dash.
//  2. Press of 30 cycles -> one new_dash. Press of 120 cycles -> no pulse.
//  3. Dot, then gap of 30 -> letter_valid=1. Hold letter_ready=0 for 5 cycles
//     -> valid stays 1. Assert ready -> clear pulse next cycle; valid=0.
//  4. symbol_count driven to 6, then a dot press -> no new_dot; overflow=1.
//     After the following clear -> overflow=0.
//  5. (WORD_GAP_EN) Letter committed, then no key for 70 cycles from release
//     -> exactly one word_gap pulse; none at 100 cycles.
//  6. rst asserted mid-press at cycle 15 -> all outputs 0, busy=0. After
//     deassert and release -> no pulse is emitted.

Source files
------------

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared states, symbol codes, unit thresholds and press classifier for the morse keyer
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_COMMIT,
    ST_CLEAR
  } state_t;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;

  localparam int DASH_UNITS   = 2;
  localparam int LETTER_UNITS = 3;
  localparam int WORD_UNITS   = 7;
  localparam int MAX_UNITS    = 10;

  // Map a press length in clk cycles to the symbol it represents; over-long presses yield none
  function automatic logic [1:0] classify_press(input logic [31:0] len, input logic [31:0] unit);
    logic [31:0] dash_lim;
    logic [31:0] max_lim;
    dash_lim = unit * 32'(DASH_UNITS);
    max_lim  = unit * 32'(MAX_UNITS);
    if (len < dash_lim)      classify_press = SYM_DOT;
    else if (len < max_lim)  classify_press = SYM_DASH;
    else                     classify_press = SYM_NONE;
  endfunction

endpackage

// File: rtl/morse_key_debounce.sv
// rtl/morse_key_debounce.sv - key synchroniser and stable-count debouncer with edge pulses
module morse_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          fill_a;
  logic          fill_b;
  logic          primed;
  logic [DW-1:0] stable_cnt;

  // Two-flop synchroniser; primed goes high once the key has been seen released after reset,
  // so a key already held through reset never produces a rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      fill_a <= 1'b0;
      fill_b <= 1'b0;
      primed <= 1'b0;
    end else begin
      sync_a <= key_in;
      sync_b <= sync_a;
      fill_a <= 1'b1;
      fill_b <= fill_a;
      primed <= primed | (fill_b & ~sync_b);
    end
  end

  // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      stable_cnt <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_b == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DB_LAST) begin
        level      <= sync_b;
        stable_cnt <= '0;
        rise       <= sync_b & primed;
        fall       <= ~sync_b;
      end else begin
        stable_cnt <= stable_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/morse_keyer_ctrl.sv
// rtl/morse_keyer_ctrl.sv - morse keyer sequencer; MORSE_CTRL_WORD_GAP_EN enables word-gap pulses
module morse_keyer_ctrl
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 1_000_000,
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int MAX_SYMBOLS     = 6,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic [2:0] symbol_count,
  output logic       new_dot,
  output logic       new_dash,
  output logic       clear,
  output logic       letter_valid,
  input  logic       letter_ready,
  output logic       word_gap,
  output logic       overflow,
  output logic       busy
);

  localparam logic [CNT_W-1:0] T_LETTER = CNT_W'(LETTER_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] T_MAX    = CNT_W'(MAX_UNITS * UNIT_CYCLES);
  localparam logic [2:0]       FULL     = 3'(MAX_SYMBOLS);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             key_level;
  logic             key_rise;
  logic             key_fall;
  logic [CNT_W:0]   press_len;
  logic [1:0]       press_sym;

  morse_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .key_in(key_in),
    .level (key_level),
    .rise  (key_rise),
    .fall  (key_fall)
  );

  // The timer reads 0 in the first cycle after the rise, so the press length includes that cycle
  assign press_len = {1'b0, timer} + (CNT_W + 1)'(1);
  assign press_sym = classify_press(32'(press_len), 32'(UNIT_CYCLES));
  assign busy      = (state != ST_IDLE);

  // Main sequencer: edge timing, press classification, letter handshake and overflow tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      new_dot      <= 1'b0;
      new_dash     <= 1'b0;
      clear        <= 1'b0;
      letter_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      new_dot  <= 1'b0;
      new_dash <= 1'b0;
      clear    <= 1'b0;

      if (key_rise || key_fall)  timer <= '0;
      else if (timer != T_MAX)   timer <= timer + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (key_rise) state <= ST_PRESS;
        end
        ST_PRESS: begin
          if (key_fall) begin
            state <= ST_GAP;
            if (press_sym != SYM_NONE) begin
              if (symbol_count >= FULL) begin
                overflow <= 1'b1;
              end else begin
                new_dot  <= (press_sym == SYM_DOT);
                new_dash <= (press_sym == SYM_DASH);
              end
            end
          end
        end
        ST_GAP: begin
          if (key_rise) begin
            state <= ST_PRESS;
          end else if (timer == T_LETTER && symbol_count != 3'd0) begin
            state        <= ST_COMMIT;
            letter_valid <= 1'b1;
          end else if (timer == T_MAX && !key_level) begin
            state <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          if (letter_valid && letter_ready) begin
            state        <= ST_CLEAR;
            letter_valid <= 1'b0;
            clear        <= 1'b1;
            overflow     <= 1'b0;
          end
          // A press starting here cannot be timed; record it as lost
          if (key_rise) overflow <= 1'b1;
        end
        ST_CLEAR: begin
          state <= ST_GAP;
          if (key_rise) overflow <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MORSE_CTRL_WORD_GAP_EN
  localparam logic [CNT_W-1:0] T_WORD = CNT_W'(WORD_UNITS * UNIT_CYCLES);

  logic wg_armed;

  // Arm after a letter is cleared, fire once at the word threshold, disarm on any new press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wg_armed <= 1'b0;
      word_gap <= 1'b0;
    end else begin
      word_gap <= 1'b0;
      if (key_rise) begin
        wg_armed <= 1'b0;
      end else if (state == ST_CLEAR) begin
        wg_armed <= 1'b1;
      end else if (state == ST_GAP && wg_armed && timer == T_WORD) begin
        word_gap <= 1'b1;
        wg_armed <= 1'b0;
      end
    end
  end
`else
  assign word_gap = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// tb/tb_morse_keyer_ctrl.sv - self-checking bench for morse_keyer_ctrl
module tb_morse_keyer_ctrl;

  localparam int UNIT = 10;
  localparam int DEB  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b0;
  logic       letter_ready = 1'b1;
  logic [2:0] symbol_count;
  logic       new_dot, new_dash, clear, letter_valid, word_gap, overflow, busy;

  int  compared = 0;
  int  mismatched = 0;
  int  dot_cnt = 0, dash_cnt = 0, clr_cnt = 0, wg_cnt = 0, both_cnt = 0;
  int  buf_count = 0;
  bit  force_full = 1'b0;

  morse_keyer_ctrl #(
    .UNIT_CYCLES(UNIT), .DEBOUNCE_CYCLES(DEB), .MAX_SYMBOLS(6), .CNT_W(24)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .symbol_count(symbol_count),
    .new_dot(new_dot), .new_dash(new_dash), .clear(clear),
    .letter_valid(letter_valid), .letter_ready(letter_ready),
    .word_gap(word_gap), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  assign symbol_count = force_full ? 3'd6 : 3'(buf_count);

  // Symbol buffer stand-in and pulse counters
  always @(negedge clk) begin
    if (rst) begin
      buf_count = 0;
    end else begin
      if (new_dot) dot_cnt++;
      if (new_dash) dash_cnt++;
      if (clear) clr_cnt++;
      if (word_gap) wg_cnt++;
      if (new_dot && new_dash) both_cnt++;
      if (clear) buf_count = 0;
      else if ((new_dot || new_dash) && buf_count < 7) buf_count++;
    end
  end

  // Reference classification: 0 none, 1 dot, 2 dash
  function automatic int expect_sym(int len);
    if (len < 2 * UNIT) return 1;
    if (len < 10 * UNIT) return 2;
    return 0;
  endfunction

  task automatic press(int len);
    @(negedge clk) key_in = 1'b1;
    repeat (len) @(negedge clk);
    key_in = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++;
    if ({new_dot, new_dash, clear, letter_valid, word_gap, overflow, busy} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {new_dot, new_dash, clear, letter_valid, word_gap, overflow, busy});
    end
    rst = 1'b0;
    idle(5);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_dot;
    int d0, h0, c0;
    d0 = dot_cnt; h0 = dash_cnt; c0 = clr_cnt;
    @(negedge clk) key_in = 1'b1;
    repeat (8) @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL dot_busy: got %b want 1", busy);
    end
    repeat (2) @(negedge clk);
    key_in = 1'b0;
    idle(10);
    compared++;
    if (dot_cnt - d0 != 1 || dash_cnt - h0 != 0) begin
      mismatched++;
      $display("FAIL dot_pulse: got dots=%0d dashes=%0d want 1/0", dot_cnt - d0, dash_cnt - h0);
    end
    idle(120);
    compared++;
    if (clr_cnt - c0 != 1) begin
      mismatched++;
      $display("FAIL dot_clear: got %0d clears want 1", clr_cnt - c0);
    end
  endtask

  task automatic test_dash_and_long;
    int d0, h0, c0;
    d0 = dot_cnt; h0 = dash_cnt;
    press(30);
    idle(10);
    compared++;
    if (dot_cnt - d0 != 0 || dash_cnt - h0 != 1) begin
      mismatched++;
      $display("FAIL dash_pulse: got dots=%0d dashes=%0d want 0/1", dot_cnt - d0, dash_cnt - h0);
    end
    idle(130);
    d0 = dot_cnt; h0 = dash_cnt; c0 = clr_cnt;
    press(120);
    idle(10);
    compared++;
    if (dot_cnt - d0 != 0 || dash_cnt - h0 != 0) begin
      mismatched++;
      $display("FAIL long_discard: got dots=%0d dashes=%0d want 0/0", dot_cnt - d0, dash_cnt - h0);
    end
    idle(130);
    compared++;
    if (clr_cnt - c0 != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL long_no_letter: got clears=%0d busy=%b want 0/0", clr_cnt - c0, busy);
    end
  endtask

  task automatic test_handshake;
    bit seen;
    letter_ready = 1'b0;
    press(10);
    idle(20);
    compared++;
    if (letter_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL valid_early: got %b want 0", letter_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (letter_valid === 1'b1) seen = 1'b1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL valid_timeout: got 0 want letter_valid=1 within bound");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if (letter_valid !== 1'b1 || clear !== 1'b0) begin
        mismatched++;
        $display("FAIL valid_hold: got valid=%b clear=%b want 1/0", letter_valid, clear);
      end
    end
    letter_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (clear !== 1'b1 || letter_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL handshake_clear: got clear=%b valid=%b want 1/0", clear, letter_valid);
    end
    @(negedge clk);
    compared++;
    if (clear !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_width: got %b want 0", clear);
    end
    idle(120);
  endtask

  task automatic test_overflow;
    int d0;
    bit seen;
    d0 = dot_cnt;
    force_full = 1'b1;
    letter_ready = 1'b0;
    press(10);
    idle(10);
    compared++;
    if (dot_cnt - d0 != 0 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow_set: got dots=%0d overflow=%b want 0/1", dot_cnt - d0, overflow);
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (letter_valid === 1'b1) seen = 1'b1;
    end
    letter_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (clear === 1'b1) seen = 1'b1;
    end
    force_full = 1'b0;
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL overflow_clear_timeout: got no clear want clear pulse");
    end
    idle(2);
    compared++;
    if (overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL overflow_cleared: got %b want 0", overflow);
    end
    idle(120);
  endtask

  task automatic test_random_letters;
    int d0, h0, c0, nd, nh, n, len, kind;
    for (int l = 0; l < 6; l++) begin
      d0 = dot_cnt; h0 = dash_cnt; c0 = clr_cnt;
      nd = 0; nh = 0;
      n = $urandom_range(1, 4);
      for (int s = 0; s < n; s++) begin
        kind = $urandom_range(0, 2);
        if (kind == 0)      len = $urandom_range(4, 17);
        else if (kind == 1) len = $urandom_range(22, 97);
        else                len = $urandom_range(103, 130);
        case (expect_sym(len))
          1: nd++;
          2: nh++;
          default: ;
        endcase
        press(len);
        if (s != n - 1) idle($urandom_range(5, 15));
      end
      idle(60);
      compared++;
      if (dot_cnt - d0 != nd || dash_cnt - h0 != nh || clr_cnt - c0 != ((nd + nh > 0) ? 1 : 0)) begin
        mismatched++;
        $display("FAIL random_letter %0d: got dots=%0d dashes=%0d clears=%0d want %0d/%0d/%0d",
                 l, dot_cnt - d0, dash_cnt - h0, clr_cnt - c0, nd, nh, (nd + nh > 0) ? 1 : 0);
      end
    end
    idle(120);
  endtask

  task automatic test_word_gap;
`ifdef MORSE_CTRL_WORD_GAP_EN
    int w0;
    w0 = wg_cnt;
    press(10);
    idle(90);
    compared++;
    if (wg_cnt - w0 != 1) begin
      mismatched++;
      $display("FAIL word_gap_once: got %0d want 1", wg_cnt - w0);
    end
    idle(40);
    compared++;
    if (wg_cnt - w0 != 1) begin
      mismatched++;
      $display("FAIL word_gap_late: got %0d want 1", wg_cnt - w0);
    end
`else
    compared++;
    if (wg_cnt != 0) begin
      mismatched++;
      $display("FAIL word_gap_disabled: got %0d pulses want 0", wg_cnt);
    end
`endif
  endtask

  task automatic test_reset_midpress;
    int d0, h0;
    d0 = dot_cnt; h0 = dash_cnt;
    @(negedge clk) key_in = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if ({new_dot, new_dash, clear, letter_valid, word_gap, overflow, busy} !== 7'b0) begin
      mismatched++;
      $display("FAIL midpress_reset: got %b want 0000000",
               {new_dot, new_dash, clear, letter_valid, word_gap, overflow, busy});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    key_in = 1'b0;
    idle(60);
    compared++;
    if (dot_cnt - d0 != 0 || dash_cnt - h0 != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midpress_no_pulse: got dots=%0d dashes=%0d busy=%b want 0/0/0",
               dot_cnt - d0, dash_cnt - h0, busy);
    end
    d0 = dot_cnt;
    press(10);
    idle(10);
    compared++;
    if (dot_cnt - d0 != 1) begin
      mismatched++;
      $display("FAIL post_reset_dot: got %0d want 1", dot_cnt - d0);
    end
    idle(120);
  endtask

  task automatic test_exclusive;
    compared++;
    if (both_cnt != 0) begin
      mismatched++;
      $display("FAIL dot_dash_exclusive: got %0d overlaps want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_dot();
    test_dash_and_long();
    test_handshake();
    test_overflow();
    test_random_letters();
    test_word_gap();
    test_reset_midpress();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
